bus_demultiplexer: RTL and testbench

//  Write side of the internal 8-bit data bus: the counterpart of the one-hot read mux.

---
 rtl/bus_demultiplexer.sv | 159 +++++++++++++++
 tb/tb_bus_demultiplexer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_demultiplexer.sv
// bus_demultiplexer: write side of the internal data bus. A legal one-hot write is staged for
// one cycle and then committed into one of ten destination latches with a per-destination load pulse.
// Ports: clk, rst_n (async, active-low), bus_in, write_en, select_0..9, err_clear
//        -> q_0..q_9, load_0..9, last_dest, busy, sel_error
//        (+ err_select when BUS_DEMUX_ERRLOG_EN is defined).
module bus_demultiplexer #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             write_en,
    input  logic             select_0,
    input  logic             select_1,
    input  logic             select_2,
    input  logic             select_3,
    input  logic             select_4,
    input  logic             select_5,
    input  logic             select_6,
    input  logic             select_7,
    input  logic             select_8,
    input  logic             select_9,
    input  logic             err_clear,
    output logic [WIDTH-1:0] q_0,
    output logic [WIDTH-1:0] q_1,
    output logic [WIDTH-1:0] q_2,
    output logic [WIDTH-1:0] q_3,
    output logic [WIDTH-1:0] q_4,
    output logic [WIDTH-1:0] q_5,
    output logic [WIDTH-1:0] q_6,
    output logic [WIDTH-1:0] q_7,
    output logic [WIDTH-1:0] q_8,
    output logic [WIDTH-1:0] q_9,
    output logic             load_0,
    output logic             load_1,
    output logic             load_2,
    output logic             load_3,
    output logic             load_4,
    output logic             load_5,
    output logic             load_6,
    output logic             load_7,
    output logic             load_8,
    output logic             load_9,
    output logic [3:0]       last_dest,
    output logic             busy,
`ifdef BUS_DEMUX_ERRLOG_EN
    output logic [9:0]       err_select,
`endif
    output logic             sel_error
);

    logic [9:0]       sel;
    logic [3:0]       hot_cnt;
    logic [3:0]       hot_idx;
    logic             wr_ok;
    logic             wr_bad;

    logic             stg_vld_q, stg_vld_d;
    logic [WIDTH-1:0] stg_data_q, stg_data_d;
    logic [3:0]       stg_idx_q, stg_idx_d;
    logic [WIDTH-1:0] mem_q [10];
    logic [9:0]       load_q, load_d;
    logic [3:0]       last_q, last_d;
    logic             err_q, err_d;

    // bit k of sel corresponds to destination k
    assign sel = {select_9, select_8, select_7, select_6, select_5,
                  select_4, select_3, select_2, select_1, select_0};

    always_comb begin
        hot_cnt = '0;
        hot_idx = '0;
        for (int k = 0; k < 10; k++) begin
            if (sel[k]) begin
                hot_cnt = hot_cnt + 4'd1;
                hot_idx = 4'(k);
            end
        end
    end

    assign wr_ok  = write_en && (hot_cnt == 4'd1);
    assign wr_bad = write_en && (hot_cnt != 4'd1);

    always_comb begin
        stg_vld_d  = wr_ok;
        stg_data_d = wr_ok ? bus_in  : stg_data_q;
        stg_idx_d  = wr_ok ? hot_idx : stg_idx_q;
        load_d     = stg_vld_q ? (10'b1 << stg_idx_q) : '0;
        last_d     = stg_vld_q ? stg_idx_q : last_q;
        // an illegal write on the clearing edge keeps the flag set
        err_d      = wr_bad ? 1'b1 : (err_clear ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_vld_q  <= 1'b0;
            stg_data_q <= '0;
            stg_idx_q  <= '0;
            load_q     <= '0;
            last_q     <= '0;
            err_q      <= 1'b0;
            for (int k = 0; k < 10; k++) mem_q[k] <= RESET_VALUE;
        end else begin
            stg_vld_q  <= stg_vld_d;
            stg_data_q <= stg_data_d;
            stg_idx_q  <= stg_idx_d;
            load_q     <= load_d;
            last_q     <= last_d;
            err_q      <= err_d;
            for (int k = 0; k < 10; k++) begin
                if (stg_vld_q && (stg_idx_q == 4'(k))) mem_q[k] <= stg_data_q;
            end
        end
    end

`ifdef BUS_DEMUX_ERRLOG_EN
    logic [9:0] sel_rev;
    logic [9:0] errsel_q, errsel_d;

    // logged pattern is ordered with select_0 in the MSB
    always_comb begin
        sel_rev = '0;
        for (int k = 0; k < 10; k++) sel_rev[9-k] = sel[k];
    end

    always_comb begin
        errsel_d = errsel_q;
        if (wr_bad && (!err_q || err_clear)) errsel_d = sel_rev;
        else if (err_clear && !wr_bad)       errsel_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) errsel_q <= '0;
        else        errsel_q <= errsel_d;
    end

    assign err_select = errsel_q;
`endif

    assign q_0 = mem_q[0];
    assign q_1 = mem_q[1];
    assign q_2 = mem_q[2];
    assign q_3 = mem_q[3];
    assign q_4 = mem_q[4];
    assign q_5 = mem_q[5];
    assign q_6 = mem_q[6];
    assign q_7 = mem_q[7];
    assign q_8 = mem_q[8];
    assign q_9 = mem_q[9];

    assign {load_9, load_8, load_7, load_6, load_5,
            load_4, load_3, load_2, load_1, load_0} = load_q;

    assign last_dest = last_q;
    assign busy      = stg_vld_q;
    assign sel_error = err_q;

endmodule

// File: tb/tb_bus_demultiplexer.sv
// tb_bus_demultiplexer: directed and randomized checks of bus_demultiplexer
// against a queue-based write-pipeline reference model.
module tb_bus_demultiplexer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] bus_in;
    logic       write_en;
    logic [9:0] sv;
    logic       err_clear;
    logic [7:0] qo [10];
    logic [9:0] lo;
    logic [3:0] last_dest;
    logic       busy;
    logic       sel_error;
`ifdef BUS_DEMUX_ERRLOG_EN
    logic [9:0] err_select;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] idx;
        logic [7:0] data;
    } wr_t;

    wr_t        pipe [$];
    logic [7:0] mq [10];
    logic [9:0] ml;
    logic [3:0] mlast;
    logic       mbusy;
    logic       merr;
    logic [9:0] mes;

    always #5 clk = ~clk;

    bus_demultiplexer dut (
        .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .write_en(write_en),
        .select_0(sv[0]), .select_1(sv[1]), .select_2(sv[2]), .select_3(sv[3]),
        .select_4(sv[4]), .select_5(sv[5]), .select_6(sv[6]), .select_7(sv[7]),
        .select_8(sv[8]), .select_9(sv[9]), .err_clear(err_clear),
        .q_0(qo[0]), .q_1(qo[1]), .q_2(qo[2]), .q_3(qo[3]), .q_4(qo[4]),
        .q_5(qo[5]), .q_6(qo[6]), .q_7(qo[7]), .q_8(qo[8]), .q_9(qo[9]),
        .load_0(lo[0]), .load_1(lo[1]), .load_2(lo[2]), .load_3(lo[3]),
        .load_4(lo[4]), .load_5(lo[5]), .load_6(lo[6]), .load_7(lo[7]),
        .load_8(lo[8]), .load_9(lo[9]),
        .last_dest(last_dest), .busy(busy),
`ifdef BUS_DEMUX_ERRLOG_EN
        .err_select(err_select),
`endif
        .sel_error(sel_error)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pipe.delete();
        for (int k = 0; k < 10; k++) mq[k] = 8'h00;
        ml    = '0;
        mlast = '0;
        mbusy = 1'b0;
        merr  = 1'b0;
        mes   = '0;
    endtask

    // one clock edge worth of behaviour, taken from the inputs seen at that edge
    task automatic model_edge();
        wr_t        w;
        int         n;
        logic [9:0] rev;
        n = $countones(sv);
        ml = '0;
        if (pipe.size() > 0) begin
            w = pipe.pop_front();
            mq[w.idx] = w.data;
            ml[w.idx] = 1'b1;
            mlast = w.idx;
        end
        for (int k = 0; k < 10; k++) rev[9-k] = sv[k];
        if (write_en && n == 1) begin
            for (int k = 0; k < 10; k++) if (sv[k]) w.idx = 4'(k);
            w.data = bus_in;
            pipe.push_back(w);
        end
        if (write_en && n != 1) begin
            if (!merr || err_clear) mes = rev;
            merr = 1'b1;
        end else if (err_clear) begin
            merr = 1'b0;
            mes  = '0;
        end
        mbusy = (pipe.size() != 0);
    endtask

    task automatic check_all(input string ph);
        for (int k = 0; k < 10; k++)
            chk($sformatf("%s_q%0d", ph, k), {8'h00, qo[k]}, {8'h00, mq[k]});
        chk({ph, "_load"}, {6'h0, lo}, {6'h0, ml});
        chk({ph, "_last"}, {12'h0, last_dest}, {12'h0, mlast});
        chk({ph, "_busy"}, {15'h0, busy}, {15'h0, mbusy});
        chk({ph, "_err"}, {15'h0, sel_error}, {15'h0, merr});
`ifdef BUS_DEMUX_ERRLOG_EN
        chk({ph, "_errsel"}, {6'h0, err_select}, {6'h0, mes});
`endif
    endtask

    task automatic drive(input logic we, input logic [9:0] s, input logic [7:0] d, input logic clr);
        write_en  = we;
        sv        = s;
        bus_in    = d;
        err_clear = clr;
    endtask

    task automatic step(input string ph);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(ph);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0, 8'h00, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        check_all("rst");
        rst_n = 1'b1;

        // reset asserted while a write sits in stage 1
        drive(1'b1, 10'b1 << 3, 8'hA5, 1'b0);
        step("midw");
        chk("midw_busy_lit", {15'h0, busy}, 16'h1);
        #2 rst_n = 1'b0;
        model_reset();
        drive(1'b0, '0, 8'h00, 1'b0);
        #2 check_all("midrst");
        chk("midrst_q3_lit", {8'h0, qo[3]}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step("postrst");
        chk("postrst_load_lit", {6'h0, lo}, 16'h0);

        // single write
        drive(1'b1, 10'b1 << 7, 8'h3C, 1'b0);
        step("w7a");
        chk("w7_busy_lit", {15'h0, busy}, 16'h1);
        drive(1'b0, '0, 8'h00, 1'b0);
        step("w7b");
        chk("w7_q_lit", {8'h0, qo[7]}, 16'h3C);
        chk("w7_load_lit", {6'h0, lo}, 16'h080);
        chk("w7_last_lit", {12'h0, last_dest}, 16'h7);
        step("w7c");

        // back-to-back to different destinations
        drive(1'b1, 10'b1 << 0, 8'h11, 1'b0);
        step("bb0");
        drive(1'b1, 10'b1 << 9, 8'h22, 1'b0);
        step("bb1");
        drive(1'b0, '0, 8'h00, 1'b0);
        step("bb2");
        step("bb3");
        chk("bb_q0_lit", {8'h0, qo[0]}, 16'h11);
        chk("bb_q9_lit", {8'h0, qo[9]}, 16'h22);

        // same-destination burst
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 10'b1 << 4, 8'(i), 1'b0);
            step($sformatf("b4_%0d", i));
        end
        drive(1'b0, '0, 8'h00, 1'b0);
        step("b4_4");
        step("b4_5");
        chk("b4_q_lit", {8'h0, qo[4]}, 16'h03);

        // illegal selects
        drive(1'b1, 10'b0000000110, 8'hEE, 1'b0);
        step("ill_a");
        drive(1'b1, 10'b0, 8'hDD, 1'b0);
        step("ill_b");
        drive(1'b0, '0, 8'h00, 1'b0);
        step("ill_c");
        chk("ill_err_lit", {15'h0, sel_error}, 16'h1);
`ifdef BUS_DEMUX_ERRLOG_EN
        chk("ill_errsel_lit", {6'h0, err_select}, 16'h180);
`endif

        // clear racing an illegal write, then clear alone
        drive(1'b1, 10'b0000010001, 8'h55, 1'b1);
        step("race_a");
        chk("race_err_lit", {15'h0, sel_error}, 16'h1);
        drive(1'b0, '0, 8'h00, 1'b1);
        step("race_b");
        chk("race_clr_lit", {15'h0, sel_error}, 16'h0);
        drive(1'b0, '0, 8'h00, 1'b0);
        step("race_c");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [9:0] s;
            if ($urandom_range(0, 5) == 0) s = 10'($urandom);
            else s = 10'b1 << $urandom_range(0, 9);
            drive(1'($urandom_range(0, 3) != 0), s, 8'($urandom),
                  1'($urandom_range(0, 9) == 0));
            step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
